// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the HD44780 write controller
package lcd_pkg;

   typedef enum logic [2:0] {
      PWRUP,
      LOAD_INIT,
      IDLE,
      SETUP,
      PULSE,
      HOLD
   } state_t;

   localparam int CMD_BIT  = 8;
   localparam int INIT_LEN = 4;

   localparam logic [7:0] INIT_FUNC_SET  = 8'h38;
   localparam logic [7:0] INIT_DISP_ON   = 8'h0C;
   localparam logic [7:0] INIT_CLEAR     = 8'h01;
   localparam logic [7:0] INIT_ENTRY     = 8'h06;

   localparam logic [7:0] CMD_CLEAR      = 8'h01;
   localparam logic [7:0] CMD_HOME       = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT   = 8'h03;

   function automatic logic [7:0] init_rom(input logic [1:0] idx);
      logic [7:0] v;
      case (idx)
         2'd0:    v = INIT_FUNC_SET;
         2'd1:    v = INIT_DISP_ON;
         2'd2:    v = INIT_CLEAR;
         default: v = INIT_ENTRY;
      endcase
      return v;
   endfunction

   // Clear/home commands need the long post-strobe wait.
   function automatic logic is_long_cmd(input logic [7:0] db);
      return (db == CMD_CLEAR) || (db == CMD_HOME) || (db == CMD_HOME_ALT);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - pointer+wrap-bit FIFO; a push into a full FIFO succeeds when a pop shares the edge
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr == r_rd);
   assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_head    = r_mem[r_rd[AW-1:0]];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
         if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/lcd_write_controller.sv
// rtl/lcd_write_controller.sv - buffers processor LCD writes and sequences RS/DB/EN, including power-up init
module lcd_write_controller
   import lcd_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int SETUP_CYC   = 2,
   parameter int PULSE_CYC   = 12,
   parameter int HOLD_CYC    = 2000,
   parameter int CLEAR_CYC   = 82000,
   parameter int POWERUP_CYC = 750000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        lcd_write,
   input  logic [31:0] lcd_data,
   output logic        lcd_en,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic [7:0]  lcd_db,
   output logic        fifo_full,
   output logic        overflow,
   output logic        busy,
   output logic        init_done
);

   localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, PULSE_CYC),
                                            max_int(HOLD_CYC, CLEAR_CYC)), POWERUP_CYC);
   localparam int CW = $clog2(MAX_CYC) + 1;

   localparam logic [CW-1:0] LD_PWRUP = CW'(POWERUP_CYC - 1);
   localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] LD_CLEAR = CW'(CLEAR_CYC - 1);
   localparam logic [1:0]    LAST_IDX = 2'(INIT_LEN - 1);

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_load;
   logic [1:0]    r_idx;
   logic          r_init_done;
   logic          r_rs;
   logic [7:0]    r_db;
   logic          r_overflow;

   logic          w_full;
   logic          w_empty;
   logic [8:0]    w_head;
   logic          w_pop;
   logic          w_cnt_zero;
   logic          w_unused_data;

   assign w_unused_data = ^lcd_data[31:9];
   assign w_cnt_zero    = (r_cnt == '0);
   assign w_pop         = (r_state == IDLE) && r_init_done && !w_empty;

   sync_fifo #(
      .WIDTH (9),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clock (clock),
      .i_reset (reset),
      .i_push  (lcd_write),
      .i_data  ({lcd_data[CMD_BIT], lcd_data[7:0]}),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= PWRUP;
         r_cnt   <= LD_PWRUP;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= w_load;
         else if (!w_cnt_zero)
            r_cnt <= r_cnt - CW'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         PWRUP:     if (w_cnt_zero) w_next = LOAD_INIT;
         LOAD_INIT: w_next = SETUP;
         IDLE:      if (r_init_done && !w_empty) w_next = SETUP;
         SETUP:     if (w_cnt_zero) w_next = PULSE;
         PULSE:     if (w_cnt_zero) w_next = HOLD;
         HOLD: begin
            if (w_cnt_zero)
               w_next = (!r_init_done && (r_idx != LAST_IDX)) ? LOAD_INIT : IDLE;
         end
         default:   w_next = PWRUP;
      endcase
   end

   // RS/DB are already latched when PULSE ends, so HOLD length is chosen from them.
   always_comb begin
      w_load = '0;
      case (w_next)
         PWRUP:   w_load = LD_PWRUP;
         SETUP:   w_load = LD_SETUP;
         PULSE:   w_load = LD_PULSE;
         HOLD:    w_load = (!r_rs && is_long_cmd(r_db)) ? LD_CLEAR : LD_HOLD;
         default: w_load = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_idx       <= '0;
         r_init_done <= 1'b0;
         r_rs        <= 1'b0;
         r_db        <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if ((r_state == HOLD) && w_cnt_zero && !r_init_done) begin
            if (r_idx == LAST_IDX)
               r_init_done <= 1'b1;
            else
               r_idx <= r_idx + 2'd1;
         end
         if (r_state == LOAD_INIT) begin
            r_rs <= 1'b0;
            r_db <= init_rom(r_idx);
         end else if (w_pop) begin
            r_rs <= !w_head[CMD_BIT];
            r_db <= w_head[7:0];
         end
         if (lcd_write && w_full && !w_pop)
            r_overflow <= 1'b1;
      end
   end

   always_comb begin
      lcd_en = (r_state == PULSE);
      busy   = (r_state != IDLE) || !w_empty;
   end

   assign lcd_rs    = r_rs;
   assign lcd_db    = r_db;
   assign lcd_rw    = 1'b0;
   assign fifo_full = w_full;
   assign overflow  = r_overflow;
   assign init_done = r_init_done;

endmodule

// File: tb/tb_lcd_write_controller.sv
// tb/tb_lcd_write_controller.sv - directed bench for lcd_write_controller with short timing parameters
module tb_lcd_write_controller;

   localparam int DEPTH       = 4;
   localparam int SETUP_CYC   = 2;
   localparam int PULSE_CYC   = 3;
   localparam int HOLD_CYC    = 4;
   localparam int CLEAR_CYC   = 10;
   localparam int POWERUP_CYC = 5;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        lcd_write = 1'b0;
   logic [31:0] lcd_data = '0;
   logic        lcd_en, lcd_rs, lcd_rw, fifo_full, overflow, busy, init_done;
   logic [7:0]  lcd_db;

   int tests = 0;
   int fails = 0;

   int q_rs[$];
   int q_db[$];
   int q_w[$];
   int q_gap[$];
   int mon_hi = 0;
   int mon_lo = 0;
   bit mon_in = 0;
   int cur_rs, cur_db, cur_gap;

   lcd_write_controller #(
      .DEPTH       (DEPTH),
      .SETUP_CYC   (SETUP_CYC),
      .PULSE_CYC   (PULSE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .CLEAR_CYC   (CLEAR_CYC),
      .POWERUP_CYC (POWERUP_CYC)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .lcd_write (lcd_write),
      .lcd_data  (lcd_data),
      .lcd_en    (lcd_en),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_db    (lcd_db),
      .fifo_full (fifo_full),
      .overflow  (overflow),
      .busy      (busy),
      .init_done (init_done)
   );

   always #5 clock = ~clock;

   // Records every EN pulse: RS/DB at rise, width, and low cycles before it.
   always @(negedge clock) begin
      if (reset) begin
         mon_in = 0;
         mon_hi = 0;
         mon_lo = 0;
      end else if (lcd_en === 1'b1) begin
         if (!mon_in) begin
            cur_rs  = int'(lcd_rs);
            cur_db  = int'(lcd_db);
            cur_gap = mon_lo;
            mon_hi  = 0;
         end
         mon_in = 1;
         mon_hi++;
      end else begin
         if (mon_in) begin
            q_rs.push_back(cur_rs);
            q_db.push_back(cur_db);
            q_w.push_back(mon_hi);
            q_gap.push_back(cur_gap);
            mon_lo = 0;
         end
         mon_in = 0;
         mon_lo++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] d);
      lcd_write = 1'b1;
      lcd_data  = d;
      step();
      lcd_write = 1'b0;
      lcd_data  = '0;
   endtask

   task automatic clear_q();
      q_rs.delete();
      q_db.delete();
      q_w.delete();
      q_gap.delete();
   endtask

   task automatic wait_pulses(input int n, input int budget, input string tag);
      int c = 0;
      while (q_w.size() < n && c < budget) begin
         step();
         c++;
      end
      chk(tag, 32'(q_w.size()), 32'(n));
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int c = 0;
      while (busy !== 1'b0 && c < budget) begin
         step();
         c++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic chk_pulse(input int i, input int rs, input int db, input int gap, input string tag);
      if (i < q_w.size()) begin
         chk({tag, "_rs"}, 32'(q_rs[i]), 32'(rs));
         chk({tag, "_db"}, 32'(q_db[i]), 32'(db));
         chk({tag, "_w"},  32'(q_w[i]),  32'(PULSE_CYC));
         if (gap >= 0) chk({tag, "_gap"}, 32'(q_gap[i]), 32'(gap));
      end
   endtask

   // Normal gap = HOLD + LOAD_INIT/IDLE + SETUP = 7; after a clear = 10 + 1 + 2 = 13.
   task automatic check_init(input string tag);
      wait_pulses(4, 200, {tag, "_init_cnt"});
      chk_pulse(0, 0, 'h38, -1, {tag, "_i0"});
      chk_pulse(1, 0, 'h0C, 7,  {tag, "_i1"});
      chk_pulse(2, 0, 'h01, 7,  {tag, "_i2"});
      chk_pulse(3, 0, 'h06, 13, {tag, "_i3"});
      wait_idle(40, {tag, "_idle"});
      chk({tag, "_init_done"}, 32'(init_done), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      step();
      step();
      chk("rst_en", 32'(lcd_en), 32'd0);
      chk("rst_rs", 32'(lcd_rs), 32'd0);
      chk("rst_rw", 32'(lcd_rw), 32'd0);
      chk("rst_db", 32'(lcd_db), 32'd0);
      chk("rst_full", 32'(fifo_full), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);

      // Init: PWRUP 5 + LOAD_INIT 1 + SETUP 2 low cycles before the first strobe.
      clear_q();
      reset = 1'b0;
      check_init("t1");
      if (q_gap.size() > 0) chk("t1_first_gap", 32'(q_gap[0]), 32'd8);
      repeat (20) step();
      chk("t1_no_extra", 32'(q_w.size()), 32'd4);

      // Single character: pop at t+1, EN high t+3..t+5, idle again at t+10.
      clear_q();
      wr(32'h0000_0041);
      step();
      chk("t2_rs", 32'(lcd_rs), 32'd1);
      chk("t2_db", 32'(lcd_db), 32'h41);
      chk("t2_en_t1", 32'(lcd_en), 32'd0);
      step();
      chk("t2_en_t2", 32'(lcd_en), 32'd0);
      step();
      chk("t2_en_t3", 32'(lcd_en), 32'd1);
      step();
      step();
      chk("t2_en_t5", 32'(lcd_en), 32'd1);
      step();
      chk("t2_en_t6", 32'(lcd_en), 32'd0);
      repeat (3) step();
      chk("t2_busy_t9", 32'(busy), 32'd1);
      step();
      chk("t2_busy_t10", 32'(busy), 32'd0);
      chk_pulse(0, 1, 'h41, -1, "t2_p");

      // Clear command followed by a character.
      clear_q();
      wr(32'h0000_0101);
      wr(32'h0000_0042);
      wait_pulses(2, 100, "t3_cnt");
      chk_pulse(0, 0, 'h01, -1, "t3_p0");
      chk_pulse(1, 1, 'h42, 13, "t3_p1");
      wait_idle(40, "t3_idle");

      // Overflow during power-up: only the first DEPTH writes survive.
      reset = 1'b1;
      step();
      reset = 1'b0;
      clear_q();
      for (int i = 0; i < 6; i++) wr(32'h31 + 32'(i));
      chk("t4_full", 32'(fifo_full), 32'd1);
      chk("t4_ovf", 32'(overflow), 32'd1);
      chk("t4_init_busy", 32'(init_done), 32'd0);
      wait_pulses(8, 300, "t4_cnt");
      chk_pulse(0, 0, 'h38, -1, "t4_i0");
      chk_pulse(3, 0, 'h06, 13, "t4_i3");
      for (int i = 0; i < 4; i++) chk_pulse(4 + i, 1, 'h31 + i, -1, "t4_d");
      wait_idle(60, "t4_idle");
      repeat (20) step();
      chk("t4_no_extra", 32'(q_w.size()), 32'd8);
      chk("t4_ovf_sticky", 32'(overflow), 32'd1);

      // Reset in the middle of a data strobe with queued bytes.
      clear_q();
      wr(32'h0000_0041);
      wr(32'h0000_0042);
      wr(32'h0000_0043);
      begin
         int c = 0;
         while (lcd_en !== 1'b1 && c < 50) begin
            step();
            c++;
         end
      end
      chk("t5_en_seen", 32'(lcd_en), 32'd1);
      step();
      reset = 1'b1;
      step();
      chk("t5_en", 32'(lcd_en), 32'd0);
      chk("t5_full", 32'(fifo_full), 32'd0);
      chk("t5_ovf", 32'(overflow), 32'd0);
      chk("t5_init_done", 32'(init_done), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      clear_q();
      check_init("t5");
      repeat (20) step();
      chk("t5_fifo_flushed", 32'(q_w.size()), 32'd4);

      // Full FIFO in IDLE: push on the pop edge is accepted without overflow.
      clear_q();
      for (int i = 0; i < 5; i++) wr(32'h50 + 32'(i));
      repeat (6) step();
      chk("t6_full_before", 32'(fifo_full), 32'd1);
      chk("t6_busy_before", 32'(busy), 32'd1);
      wr(32'h0000_0055);
      chk("t6_full_after", 32'(fifo_full), 32'd1);
      chk("t6_ovf", 32'(overflow), 32'd0);
      chk("t6_pop_db", 32'(lcd_db), 32'h51);
      chk("t6_pop_rs", 32'(lcd_rs), 32'd1);
      wait_pulses(6, 200, "t6_cnt");
      for (int i = 0; i < 6; i++) chk_pulse(i, 1, 'h50 + i, (i == 0) ? -1 : 7, "t6_d");
      wait_idle(40, "t6_idle");
      chk("t6_ovf_end", 32'(overflow), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
